from_serial: RTL

FROM_SERIAL -- requirements
Module: from_serial

---
 rtl/serial_pkg.sv | 15 +
 rtl/from_serial_lane.sv | 27 ++
 rtl/from_serial.sv | 56 +++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared defaults and counter-width helpers for to_serial / from_serial.
package serial_pkg;
   localparam int DEF_NO_CH  = 64;
   localparam int DEF_BW_SER = 1;
   localparam int DEF_BW_PAR = 16;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int cnt_w(input int n);
      return n > 1 ? clog2(n) : 1;
   endfunction
endpackage

// File: rtl/from_serial_lane.sv
// from_serial_lane: one channel's LSB-first shift register plus held output word.
module from_serial_lane
   import serial_pkg::*;
#(
   parameter int BW_IN  = DEF_BW_SER,
   parameter int BW_OUT = DEF_BW_PAR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift,
   input  logic              load,
   input  logic [BW_IN-1:0]  d,
   output logic [BW_OUT-1:0] q
);
   logic [BW_OUT-1:0] sh, word;
   // New beat enters at the top; after NUM_CYC beats beat 0 sits at the LSBs.
   assign word = (sh >> BW_IN) | (BW_OUT'(d) << (BW_OUT - BW_IN));
   always_ff @(posedge clk) begin
      if (rst) begin
         sh <= '0;
         q  <= '0;
      end else begin
         if (shift) sh <= word;
         if (load) q <= word;
      end
   end
endmodule

// File: rtl/from_serial.sv
// from_serial: per-channel deserializer, NO_CH lanes sharing one beat counter.
// Optional FROM_SERIAL_SYNC_EN adds sync_in to restart word alignment.
module from_serial
   import serial_pkg::*;
#(
   parameter int NO_CH  = DEF_NO_CH,
   parameter int BW_IN  = DEF_BW_SER,
   parameter int BW_OUT = DEF_BW_PAR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vld_in,
   input  logic [NO_CH*BW_IN-1:0]  data_in,
`ifdef FROM_SERIAL_SYNC_EN
   input  logic                    sync_in,
`endif
   output logic                    vld_out,
   output logic [NO_CH*BW_OUT-1:0] data_out
);
   localparam int NUM_CYC = BW_OUT / BW_IN;
   localparam int CW = cnt_w(NUM_CYC);
   localparam logic [CW-1:0] LAST = CW'(NUM_CYC - 1);
   if (BW_OUT % BW_IN != 0 || (NUM_CYC & (NUM_CYC - 1)) != 0) begin : g_bad
      $error("from_serial: BW_OUT must be BW_IN times a power of two");
   end
   logic [CW-1:0] cnt, start, cnt_nxt;
   logic          last;
   always_comb begin
`ifdef FROM_SERIAL_SYNC_EN
      start = sync_in ? '0 : cnt;
`else
      start = cnt;
`endif
      last    = vld_in && start == LAST;
      cnt_nxt = !vld_in ? start : last ? '0 : start + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         vld_out <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         vld_out <= last;
      end
   end
   for (genvar c = 0; c < NO_CH; c++) begin : g_lane
      from_serial_lane #(.BW_IN(BW_IN), .BW_OUT(BW_OUT)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .shift(vld_in),
         .load (last),
         .d    (data_in[c*BW_IN +: BW_IN]),
         .q    (data_out[c*BW_OUT +: BW_OUT])
      );
   end
endmodule
